softmax_result_collector: RTL and testbench
===========================================

# softmax_result_collector

Downstream consumer of the pseudo-softmax datapath. Accepts one reduced-float result per element, `{exp[3:0], mant[2:0]}`, and converts it to an unsigned Q0.8 probability. It buffers a full vector of `N` results, then drains them in order over a valid/ready handshake, marking the last element. An optional argmax tracker reports the index of the largest probability in each vector.

## Interface

Parameters
- `N`, default 4: elements per vector; power of two, 2..16.
- `IW`, default `$clog2(N)`: index width.

Ports
- `clk` in 1: single clock, all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: result present on `exp_in`/`mant_in`.
- `in_ready` out 1: collector can accept a result.
- `exp_in` in 4: exponent `e`; value = 1.mmm × 2^(−e).
- `mant_in` in 3: mantissa fraction `mmm`.
- `out_valid` out 1: `out_data` holds a valid probability.
- `out_ready` in 1: consumer accepts the current output.
- `out_data` out 8: Q0.8 probability.
- `out_index` out IW: element index of `out_data`.
- `out_last` out 1: high with element `N−1`.
- `argmax_idx` out IW: index of the maximum element (`ARGMAX_EN` only).
- `argmax_valid` out 1: `argmax_idx` is valid (`ARGMAX_EN` only).

## Operation

- Conversion (combinational, at input accept): `q9 = {1'b1, mant_in} << 5 >> exp_in`, computed 9 bits wide.
  - `out = (q9 > 255) ? 8'd255 : q9[7:0]`.
  - Any `e ≥ 9` gives 0.
- Storage: N×8 register buffer. The converted value is written at slot `wr_cnt`.
- FSM with two states, FILL and DRAIN.
- FILL:
  - `in_ready = 1`, `out_valid = 0`.
  - On accept (`in_valid && in_ready`): write slot `wr_cnt`, then `wr_cnt++`.
  - On the accept where `wr_cnt == N−1`: go to DRAIN, `wr_cnt ← 0`, `rd_cnt ← 0`.
- DRAIN:
  - `in_ready = 0`; inputs are ignored.
  - `out_valid = 1`, `out_data = buf[rd_cnt]`, `out_index = rd_cnt`, `out_last = (rd_cnt == N−1)`.
  - On handshake (`out_valid && out_ready`): `rd_cnt++`.
  - On the handshake with `out_last`: go to FILL.
- Outputs hold stable while `out_valid && !out_ready`.
- No pass-through: the next vector is not accepted until the previous vector has fully drained.
- Reset (any state, including mid-fill or mid-drain):
  - Next state FILL; `wr_cnt`, `rd_cnt` ← 0.
  - `out_valid`, `out_data`, `out_index`, `out_last`, `argmax_idx`, `argmax_valid` ← 0.
  - Buffer contents are don't-care; a partial vector is discarded.
  - `in_ready` reads 0 in the reset cycle and 1 in the first cycle after reset.

## Timing

- Input throughput: 1 result per cycle in FILL.
- First output: `out_valid` rises the cycle after the N-th input accept.
- Output throughput: 1 element per cycle with `out_ready` held high. Minimum vector period is 2N cycles.
- `in_ready` rises the cycle after the `out_last` handshake.
- All outputs are registered or decoded from registered state only.
- There is no combinational path from `in_valid` or `out_ready` to any output.

## Configuration

- Macro `SOFTMAX_COLLECTOR_ARGMAX_EN`.
- Defined:
  - A running max register and index update on each FILL accept when `q > max` (strict). Ties keep the lower index.
  - Element 0 always loads the running max.
  - On entry to DRAIN: `argmax_idx ← running index`, `argmax_valid ← 1`.
  - Both hold through DRAIN; `argmax_valid` clears on return to FILL.
- Undefined:
  - `argmax_idx` and `argmax_valid` tied to 0 and kept in the port list.
  - No max registers are synthesized.

## Structure

- Shared package `softmax_pkg` holds:
  - `EXP_W = 4`, `MANT_W = 3`, `PROB_W = 8`.
  - The state enum `{S_FILL, S_DRAIN}`.
  - Function `flp_to_q08(exp, mant)`, shared with any future stage that reads the reduced format.
- One sub-module, `flp_to_prob`: the combinational converter with saturation. It is instantiated once on the input path.

## Test plan

- Conversion sweep, N=4, out_ready=1. Inputs (e,m) = (0,0), (1,0), (3,4), (9,7) → outputs 255, 128, 48, 0 with indices 0..3. `out_last` is high only on the 4th output.
- Backpressure: `out_ready` low for 3 cycles mid-drain → `out_data`/`out_index` held, no element lost or duplicated. `in_ready` stays 0 until the cycle after the `out_last` handshake.
- Back-to-back vectors: `in_valid` held high for 8 cycles with distinct data → first 4 accepted, the next 4 ignored while `in_ready = 0`. Only the first vector is emitted.
- Reset mid-fill: after 2 accepts, assert `rst` 1 cycle, then send 4 new results → output is exactly the 4 new values. All outputs read 0 in the cycle after reset.
- Argmax (macro defined): inputs (2,5), (1,2), (1,2), (4,0) → q = 104, 160, 160, 16, so `argmax_idx = 1` (tie keeps lowest index). `argmax_valid` is high throughout DRAIN and low after.
- Macro undefined: same stimulus → `argmax_valid = 0` and `argmax_idx = 0` throughout.

Source files
------------

// File: rtl/softmax_pkg.sv
// Shared definitions for the pseudo-softmax result path: field widths,
// collector FSM states and the reduced-float to Q0.8 conversion.
package softmax_pkg;

    localparam int EXP_W  = 4;
    localparam int MANT_W = 3;
    localparam int PROB_W = 8;

    typedef enum logic {
        S_FILL  = 1'b0,
        S_DRAIN = 1'b1
    } state_t;

    // Value is 1.mmm * 2^-e. Aligning 1.mmm so that 1.0 lands on bit 8 gives a
    // 9-bit Q1.8 value. Anything >= 1.0 saturates to the largest Q0.8 code.
    // Exponents of 9 and above shift every bit out and yield 0.
    function automatic logic [PROB_W-1:0] flp_to_q08(
        input logic [EXP_W-1:0]  exp_v,
        input logic [MANT_W-1:0] mant_v
    );
        logic [8:0] q9;
        q9 = {1'b1, mant_v, 5'b00000} >> exp_v;
        return (q9 > 9'd255) ? 8'd255 : q9[7:0];
    endfunction

endpackage

// File: rtl/flp_to_prob.sv
// Combinational reduced-float {exp, mant} to saturated Q0.8 probability.
module flp_to_prob
    import softmax_pkg::*;
(
    input  logic [EXP_W-1:0]  exp_in,
    input  logic [MANT_W-1:0] mant_in,
    output logic [PROB_W-1:0] prob
);

    assign prob = flp_to_q08(exp_in, mant_in);

endmodule

// File: rtl/softmax_result_collector.sv
// Collects N converted softmax results, then drains them in order over a
// valid/ready handshake with an index and last marker.
// Optional argmax tracking is enabled by defining SOFTMAX_COLLECTOR_ARGMAX_EN;
// without it argmax_idx/argmax_valid are tied to 0.
module softmax_result_collector
    import softmax_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [EXP_W-1:0]  exp_in,
    input  logic [MANT_W-1:0] mant_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PROB_W-1:0] out_data,
    output logic [IW-1:0]     out_index,
    output logic              out_last,
    output logic [IW-1:0]     argmax_idx,
    output logic              argmax_valid
);

    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    state_t               state_reg, state_next;
    logic [IW-1:0]        wr_cnt_reg, wr_cnt_next;
    logic [IW-1:0]        rd_cnt_reg, rd_cnt_next;
    logic [PROB_W-1:0]    prob_in;
    logic                 accept;
    logic                 fill_done;
    logic                 drain_done;
    logic [N-1:0][PROB_W-1:0] slot_data;

    flp_to_prob u_conv (
        .exp_in  (exp_in),
        .mant_in (mant_in),
        .prob    (prob_in)
    );

    // Ready is masked during reset so nothing is accepted in the reset cycle.
    assign in_ready   = (state_reg == S_FILL) && !rst;
    assign accept     = in_valid && in_ready;
    assign fill_done  = accept && (wr_cnt_reg == LAST_IDX);
    assign drain_done = (state_reg == S_DRAIN) && out_ready && (rd_cnt_reg == LAST_IDX);

    // Outputs are decoded from registered state; data is forced to 0 outside
    // DRAIN so stale buffer contents never show after reset.
    assign out_valid = (state_reg == S_DRAIN);
    assign out_data  = out_valid ? slot_data[rd_cnt_reg] : '0;
    assign out_index = out_valid ? rd_cnt_reg : '0;
    assign out_last  = out_valid && (rd_cnt_reg == LAST_IDX);

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= S_FILL;
            wr_cnt_reg <= '0;
            rd_cnt_reg <= '0;
        end else begin
            state_reg  <= state_next;
            wr_cnt_reg <= wr_cnt_next;
            rd_cnt_reg <= rd_cnt_next;
        end
    end

    // Next-state logic: fill N slots, then drain N slots, never overlapping.
    always_comb begin
        state_next  = state_reg;
        wr_cnt_next = wr_cnt_reg;
        rd_cnt_next = rd_cnt_reg;
        case (state_reg)
            S_FILL: begin
                if (accept) begin
                    wr_cnt_next = wr_cnt_reg + 1'b1;
                    if (wr_cnt_reg == LAST_IDX) begin
                        state_next  = S_DRAIN;
                        wr_cnt_next = '0;
                        rd_cnt_next = '0;
                    end
                end
            end
            S_DRAIN: begin
                if (out_ready) begin
                    rd_cnt_next = rd_cnt_reg + 1'b1;
                    if (rd_cnt_reg == LAST_IDX) begin
                        state_next  = S_FILL;
                        rd_cnt_next = '0;
                    end
                end
            end
            default: begin
                state_next = S_FILL;
            end
        endcase
    end

    // One holding register per slot; contents are don't-care after reset.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_slot
            logic [PROB_W-1:0] slot_reg;

            // Capture the converted value when this slot is the write target.
            always_ff @(posedge clk) begin
                if (accept && (wr_cnt_reg == IW'(gi))) begin
                    slot_reg <= prob_in;
                end
            end

            assign slot_data[gi] = slot_reg;
        end
    endgenerate

`ifdef SOFTMAX_COLLECTOR_ARGMAX_EN
    logic [PROB_W-1:0] max_reg;
    logic [IW-1:0]     max_idx_reg;
    logic [IW-1:0]     max_idx_next;
    logic              max_take;
    logic [IW-1:0]     argmax_idx_reg;
    logic              argmax_valid_reg;

    // Element 0 always seeds the running max; later elements replace it only
    // when strictly larger, so ties keep the lowest index.
    always_comb begin
        max_take     = (wr_cnt_reg == '0) || (prob_in > max_reg);
        max_idx_next = max_take ? wr_cnt_reg : max_idx_reg;
    end

    // Running max during FILL; publish the winner on entry to DRAIN.
    always_ff @(posedge clk) begin
        if (rst) begin
            max_reg          <= '0;
            max_idx_reg      <= '0;
            argmax_idx_reg   <= '0;
            argmax_valid_reg <= 1'b0;
        end else begin
            if (accept && max_take) begin
                max_reg     <= prob_in;
                max_idx_reg <= wr_cnt_reg;
            end
            if (fill_done) begin
                argmax_idx_reg   <= max_idx_next;
                argmax_valid_reg <= 1'b1;
            end else if (drain_done) begin
                argmax_valid_reg <= 1'b0;
            end
        end
    end

    assign argmax_idx   = argmax_idx_reg;
    assign argmax_valid = argmax_valid_reg;
`else
    assign argmax_idx   = '0;
    assign argmax_valid = 1'b0;
`endif

endmodule

// File: tb/tb_softmax_result_collector.sv
// Directed bench for softmax_result_collector (N=4). Expected values are
// hand-computed from q9 = {1,mmm,00000} >> e with saturation at 255.
module tb_softmax_result_collector;

    localparam int N  = 4;
    localparam int IW = 2;
`ifdef SOFTMAX_COLLECTOR_ARGMAX_EN
    localparam bit ARG_EN = 1'b1;
`else
    localparam bit ARG_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [3:0]    exp_in = '0;
    logic [2:0]    mant_in = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [7:0]    out_data;
    logic [IW-1:0] out_index;
    logic          out_last;
    logic [IW-1:0] argmax_idx;
    logic          argmax_valid;

    int n_cmp = 0;
    int n_mis = 0;
    int exp_d [N];
    int exp_arg;

    softmax_result_collector #(.N(N), .IW(IW)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .exp_in       (exp_in),
        .mant_in      (mant_in),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_index    (out_index),
        .out_last     (out_last),
        .argmax_idx   (argmax_idx),
        .argmax_valid (argmax_valid)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_mis++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, expv);
        end
    endtask

    // Present one result at a negedge; it is accepted on the following posedge.
    task automatic push(input int e, input int m);
        check_val("push_in_ready", 32'(in_ready), 1);
        in_valid = 1'b1;
        exp_in   = 4'(e);
        mant_in  = 3'(m);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        $display("push e=%0d m=%0d", e, m);
    endtask

    task automatic check_idle(input string tag);
        check_val({tag, "_out_valid"}, 32'(out_valid), 0);
        check_val({tag, "_in_ready"}, 32'(in_ready), 1);
        check_val({tag, "_argmax_valid"}, 32'(argmax_valid), 0);
        if (!ARG_EN) check_val({tag, "_argmax_idx"}, 32'(argmax_idx), 0);
    endtask

    // Drain one vector against exp_d/exp_arg, optionally stalling 3 cycles
    // on element stall_at.
    task automatic drain(input int stall_at);
        int waited;
        waited    = 0;
        out_ready = 1'b1;
        while (!out_valid && waited < 20) begin
            @(posedge clk);
            @(negedge clk);
            waited++;
        end
        if (!out_valid) begin
            check_val("drain_timeout", 0, 1);
            out_ready = 1'b0;
            return;
        end
        check_val("first_latency", 32'(waited), 0);
        for (int i = 0; i < N; i++) begin
            check_val("out_valid", 32'(out_valid), 1);
            check_val("out_data", 32'(out_data), 32'(exp_d[i]));
            check_val("out_index", 32'(out_index), 32'(i));
            check_val("out_last", 32'(out_last), (i == N - 1) ? 1 : 0);
            check_val("drain_in_ready", 32'(in_ready), 0);
            check_val("argmax_valid", 32'(argmax_valid), ARG_EN ? 1 : 0);
            check_val("argmax_idx", 32'(argmax_idx), ARG_EN ? 32'(exp_arg) : 0);
            $display("drain idx=%0d data=%0d last=%0d argmax=%0d/%0d",
                     out_index, out_data, out_last, argmax_valid, argmax_idx);
            if (i == stall_at) begin
                out_ready = 1'b0;
                repeat (3) begin
                    @(posedge clk);
                    @(negedge clk);
                    check_val("stall_valid", 32'(out_valid), 1);
                    check_val("stall_data", 32'(out_data), 32'(exp_d[i]));
                    check_val("stall_index", 32'(out_index), 32'(i));
                    check_val("stall_in_ready", 32'(in_ready), 0);
                end
                out_ready = 1'b1;
            end
            @(posedge clk);
            @(negedge clk);
        end
        out_ready = 1'b0;
        check_idle("post_drain");
    endtask

    initial begin
        // Reset state.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_val("rst_in_ready", 32'(in_ready), 0);
        check_val("rst_out_valid", 32'(out_valid), 0);
        rst = 1'b0;
        #1;
        check_val("reset_out_data", 32'(out_data), 0);
        check_val("reset_out_index", 32'(out_index), 0);
        check_val("reset_out_last", 32'(out_last), 0);
        check_val("reset_argmax_idx", 32'(argmax_idx), 0);
        check_idle("reset");

        // Conversion sweep: saturation, exact power, mid value, underflow.
        exp_d   = '{255, 128, 48, 0};
        exp_arg = 0;
        push(0, 0); push(1, 0); push(3, 4); push(9, 7);
        drain(-1);

        // Argmax with a tie plus 3-cycle backpressure on element 1.
        exp_d   = '{104, 160, 160, 16};
        exp_arg = 1;
        push(2, 5); push(1, 2); push(1, 2); push(4, 0);
        drain(1);

        // Back-to-back: 8 cycles of valid while out_ready is low; only the
        // first 4 may be taken.
        out_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check_val("b2b_in_ready", 32'(in_ready), (k < 4) ? 1 : 0);
            in_valid = 1'b1;
            exp_in   = 4'(k);
            mant_in  = 3'd1;
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        exp_d   = '{255, 144, 72, 36};
        exp_arg = 0;
        drain(-1);
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            check_val("b2b_no_extra", 32'(out_valid), 0);
        end

        // Reset mid-fill discards the partial vector.
        push(5, 0); push(6, 0);
        rst = 1'b1;
        #1;
        check_val("midrst_in_ready", 32'(in_ready), 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_val("midrst_out_data", 32'(out_data), 0);
        check_val("midrst_out_index", 32'(out_index), 0);
        check_val("midrst_out_last", 32'(out_last), 0);
        check_val("midrst_argmax_idx", 32'(argmax_idx), 0);
        check_idle("midrst");
        exp_d   = '{255, 64, 40, 1};
        exp_arg = 0;
        push(0, 7); push(2, 0); push(3, 2); push(8, 0);
        drain(-1);
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            check_val("midrst_no_extra", 32'(out_valid), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    // Absolute time guard so the run always terminates.
    initial begin
        #100000;
        $display("FAIL global_timeout: got 1, want 0");
        $fatal(1, "simulation time limit");
    end

endmodule
